// File: rtl/iod_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module : iod_delay_ctrl
// Brief  : Dynamic I/O delay-line controller. Steps taps one at a time with
//          settle time, tracks the current tap and reports done/out-of-range.
// Rev    : 1.0  initial release
// ============================================================================
module iod_delay_ctrl #(
    parameter int TAP_W         = 7,
    parameter int MAX_TAP       = 127,
    parameter int DEFAULT_TAP   = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             ARST_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_RELOAD,
    input  logic [TAP_W-1:0] REQ_TAP,
    output logic             DONE,
    output logic             ERR,
    output logic [TAP_W-1:0] CUR_TAP,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD,
    input  logic             DELAY_LINE_OUT_OF_RANGE
);

    localparam int               CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] MAX_TAP_V   = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] DEF_TAP_V   = TAP_W'(DEFAULT_TAP);

    // What started the current settle window decides where it ends.
    localparam logic [1:0] SRC_INIT = 2'd0;
    localparam logic [1:0] SRC_LOAD = 2'd1;
    localparam logic [1:0] SRC_MOVE = 2'd2;

    typedef enum logic [2:0] {
        ST_INIT_LOAD = 3'd0,
        ST_IDLE      = 3'd1,
        ST_LOAD      = 3'd2,
        ST_SETUP     = 3'd3,
        ST_MOVE      = 3'd4,
        ST_SETTLE    = 3'd5,
        ST_FIN       = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAP_W-1:0] cur_q, cur_d;
    logic [TAP_W-1:0] target_q, target_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic [1:0]       src_q, src_d;
    logic             armed_q, armed_d;

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q  <= ST_INIT_LOAD;
            cnt_q    <= '0;
            cur_q    <= DEF_TAP_V;
            target_q <= DEF_TAP_V;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
            src_q    <= SRC_INIT;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            target_q <= target_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
            src_q    <= src_d;
            armed_q  <= armed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        target_d = target_q;
        dir_d    = dir_q;
        err_d    = err_q;
        src_d    = src_q;
        armed_d  = armed_q;
        case (state_q)
            // The first clock after reset release arms the pulse so that
            // LOAD stays low while ARST_N is still asserted.
            ST_INIT_LOAD: begin
                if (!armed_q) begin
                    armed_d = 1'b1;
                end else begin
                    cur_d   = DEF_TAP_V;
                    cnt_d   = SETTLE_LAST;
                    src_d   = SRC_INIT;
                    state_d = ST_SETTLE;
                end
            end
            ST_IDLE: begin
                if (REQ_VALID) begin
                    err_d = 1'b0;
                    if (REQ_RELOAD) begin
                        state_d = ST_LOAD;
                    end else if (REQ_TAP > MAX_TAP_V) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else if (REQ_TAP == cur_q) begin
                        state_d = ST_FIN;
                    end else begin
                        target_d = REQ_TAP;
                        state_d  = ST_SETUP;
                    end
                end
            end
            ST_LOAD: begin
                cur_d   = DEF_TAP_V;
                cnt_d   = SETTLE_LAST;
                src_d   = SRC_LOAD;
                state_d = ST_SETTLE;
            end
            ST_SETUP: begin
                dir_d   = (target_q > cur_q);
                state_d = ST_MOVE;
            end
            ST_MOVE: begin
                cur_d   = dir_q ? cur_q + 1'b1 : cur_q - 1'b1;
                cnt_d   = SETTLE_LAST;
                src_d   = SRC_MOVE;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Out-of-range only means something after a step; undo it.
                if ((src_q == SRC_MOVE) && DELAY_LINE_OUT_OF_RANGE) begin
                    cur_d   = dir_q ? cur_q - 1'b1 : cur_q + 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else if (cnt_q == '0) begin
                    if (src_q == SRC_INIT) begin
                        state_d = ST_IDLE;
                    end else if (src_q == SRC_LOAD) begin
                        state_d = ST_FIN;
                    end else if (cur_q == target_q) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT_LOAD;
            end
        endcase
    end

    assign REQ_READY            = (state_q == ST_IDLE);
    assign DONE                 = (state_q == ST_FIN);
    assign ERR                  = err_q;
    assign CUR_TAP              = cur_q;
    assign DELAY_LINE_MOVE      = (state_q == ST_MOVE);
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_LOAD      = (state_q == ST_LOAD) || ((state_q == ST_INIT_LOAD) && armed_q);

endmodule
`default_nettype wire

// File: tb/tb_iod_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_iod_delay_ctrl
// Brief  : Table-driven bench for iod_delay_ctrl plus reset sequences.
// Rev    : 1.0  initial release
// ============================================================================
module tb_iod_delay_ctrl;

    localparam int TAP_W = 8;

    logic             CLK = 1'b0;
    logic             ARST_N = 1'b0;
    logic             REQ_VALID = 1'b0;
    logic             REQ_READY;
    logic             REQ_RELOAD = 1'b0;
    logic [TAP_W-1:0] REQ_TAP = '0;
    logic             DONE;
    logic             ERR;
    logic [TAP_W-1:0] CUR_TAP;
    logic             MOVE;
    logic             DIR;
    logic             LOAD;
    logic             OOR = 1'b0;

    iod_delay_ctrl #(
        .TAP_W        (TAP_W),
        .MAX_TAP      (127),
        .DEFAULT_TAP  (1),
        .SETTLE_CYCLES(4)
    ) dut (
        .CLK                    (CLK),
        .ARST_N                 (ARST_N),
        .REQ_VALID              (REQ_VALID),
        .REQ_READY              (REQ_READY),
        .REQ_RELOAD             (REQ_RELOAD),
        .REQ_TAP                (REQ_TAP),
        .DONE                   (DONE),
        .ERR                    (ERR),
        .CUR_TAP                (CUR_TAP),
        .DELAY_LINE_MOVE        (MOVE),
        .DELAY_LINE_DIRECTION   (DIR),
        .DELAY_LINE_LOAD        (LOAD),
        .DELAY_LINE_OUT_OF_RANGE(OOR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rl;
        logic [7:0] tap;
        int         oor_after;  // 0 = never, <0 = held high throughout
        int         exp_done;
        int         exp_cur;
        int         exp_err;
        int         exp_moves;
        int         exp_loads;
        logic       exp_dir;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Releases reset at a falling edge and watches the INIT_LOAD sequence.
    task automatic check_release(input string tag);
        int load_mask   = 0;
        int ready_first = 0;
        int spurious    = 0;
        @(negedge CLK);
        ARST_N = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            if (LOAD) load_mask |= (1 << c);
            if (REQ_READY && ready_first == 0) ready_first = c;
            if (DONE || MOVE) spurious++;
        end
        chk({tag, "_load_cycle1_only"}, load_mask, 32'd2);
        chk({tag, "_ready_rise_cycle"}, ready_first, 32'd6);
        chk({tag, "_no_done_or_move"}, spurious, 32'd0);
        chk({tag, "_cur_tap"}, CUR_TAP, 32'd1);
        chk({tag, "_err"}, ERR, 32'd0);
    endtask

    task automatic issue(input string tag, input logic rl, input logic [7:0] tap);
        int waited = 0;
        @(negedge CLK);
        while (!REQ_READY && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        if (!REQ_READY) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
        REQ_VALID  = 1'b1;
        REQ_RELOAD = rl;
        REQ_TAP    = tap;
        @(posedge CLK);
        #1;
        REQ_VALID  = 1'b0;
        REQ_RELOAD = 1'b0;
        REQ_TAP    = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        int    moves = 0;
        int    loads = 0;
        int    done_c = 0;
        int    pin_bad = 0;
        tag = $sformatf("v%0d", idx);
        if (v.oor_after < 0) OOR = 1'b1;
        issue(tag, v.rl, v.tap);
        for (int c = 1; c <= 1000; c++) begin
            @(negedge CLK);
            if (MOVE && LOAD) pin_bad++;
            if (REQ_READY) pin_bad++;
            if (MOVE) begin
                moves++;
                if (DIR !== v.exp_dir) pin_bad++;
                if (v.oor_after > 0 && moves == v.oor_after) OOR = 1'b1;
            end
            if (LOAD) loads++;
            if (DONE) begin
                done_c = c;
                break;
            end
        end
        OOR = 1'b0;
        chk({tag, "_done_cycle"}, done_c, v.exp_done);
        chk({tag, "_cur_tap"}, CUR_TAP, v.exp_cur);
        chk({tag, "_err"}, ERR, v.exp_err);
        chk({tag, "_moves"}, moves, v.exp_moves);
        chk({tag, "_loads"}, loads, v.exp_loads);
        chk({tag, "_pins_ok"}, pin_bad, 32'd0);
    endtask

    initial begin
        int moves;
        //          rl    tap     oor done cur err mv ld dir
        vecs[0]  = '{1'b0, 8'd4,   0,  19,  4,  0, 3, 0, 1'b1};
        vecs[1]  = '{1'b0, 8'd2,   0,  13,  2,  0, 2, 0, 1'b0};
        vecs[2]  = '{1'b0, 8'd2,   0,   1,  2,  0, 0, 0, 1'b0};
        vecs[3]  = '{1'b0, 8'd200, 0,   1,  2,  1, 0, 0, 1'b0};
        vecs[4]  = '{1'b0, 8'd10,  3,  16,  4,  1, 3, 0, 1'b1};
        vecs[5]  = '{1'b0, 8'd4,   0,   1,  4,  0, 0, 0, 1'b0};
        vecs[6]  = '{1'b1, 8'd50,  0,   6,  1,  0, 0, 1, 1'b0};
        vecs[7]  = '{1'b0, 8'd0,   0,   7,  0,  0, 1, 0, 1'b0};
        vecs[8]  = '{1'b0, 8'd127, 0, 763, 127, 0, 127, 0, 1'b1};
        vecs[9]  = '{1'b0, 8'd128, 0,   1, 127, 1, 0, 0, 1'b0};
        vecs[10] = '{1'b1, 8'd0,  -1,   6,  1,  0, 0, 1, 1'b0};

        repeat (3) @(negedge CLK);
        chk("rst_ready", REQ_READY, 32'd0);
        chk("rst_done", DONE, 32'd0);
        chk("rst_err", ERR, 32'd0);
        chk("rst_move", MOVE, 32'd0);
        chk("rst_load", LOAD, 32'd0);
        chk("rst_dir", DIR, 32'd0);
        chk("rst_cur_tap", CUR_TAP, 32'd1);

        check_release("init");

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Abort in the middle of the second step of a climb from tap 1.
        issue("midrst", 1'b0, 8'd20);
        moves = 0;
        for (int c = 1; c <= 100 && moves < 2; c++) begin
            @(negedge CLK);
            if (MOVE) moves++;
        end
        chk("midrst_move_seen", moves, 32'd2);
        chk("midrst_pre_move", MOVE, 32'd1);
        chk("midrst_pre_dir", DIR, 32'd1);
        chk("midrst_pre_cur", CUR_TAP, 32'd2);
        #2 ARST_N = 1'b0;
        #1;
        chk("midrst_move", MOVE, 32'd0);
        chk("midrst_dir", DIR, 32'd0);
        chk("midrst_cur", CUR_TAP, 32'd1);
        chk("midrst_ready", REQ_READY, 32'd0);
        chk("midrst_load", LOAD, 32'd0);
        repeat (2) @(negedge CLK);
        check_release("reinit");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
